// File: rtl/ps2_host_tx_if.sv
// Host-transmit handshake and PS/2 open-drain line signals for ps2_host_tx.
// slave is the transmitter's view; master is the view of whatever drives it.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_start, ps2_clk_in, ps2_data_in,
        input  tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
        output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift of
// {stop, odd parity, data}, then ACK check, with a watchdog over the device-clocked phase.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);
    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] inh_cnt, inh_cnt_n;
    logic [WW-1:0] wd_cnt, wd_cnt_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [9:0]    frame, frame_n;
    logic          clk_oe, clk_oe_n;
    logic          data_oe, data_oe_n;
    logic          busy, busy_n;
    logic          done, done_n;
    logic          err, err_n;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    logic          sync_clk, sync_data, fall;

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];
    assign fall      = clk_prev & ~sync_clk;

    // Synchronisers reset to the idle-high line level so no false fall follows reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk_in};
            data_sync <= {data_sync[0], bus.ps2_data_in};
            clk_prev  <= sync_clk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            inh_cnt <= '0;
            wd_cnt  <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            inh_cnt <= inh_cnt_n;
            wd_cnt  <= wd_cnt_n;
            bit_cnt <= bit_cnt_n;
            frame   <= frame_n;
            clk_oe  <= clk_oe_n;
            data_oe <= data_oe_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        inh_cnt_n = inh_cnt;
        wd_cnt_n  = wd_cnt;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        clk_oe_n  = clk_oe;
        data_oe_n = data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (bus.tx_start) begin
                    frame_n   = {1'b1, ~^bus.tx_data, bus.tx_data};
                    inh_cnt_n = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_n = 1'b1;
                    state_n   = S_RTS;
                end else begin
                    inh_cnt_n = inh_cnt + 1'b1;
                end
            end
            S_RTS: begin
                clk_oe_n  = 1'b0;
                wd_cnt_n  = '0;
                bit_cnt_n = '0;
                state_n   = S_SHIFT;
            end
            S_SHIFT: begin
                // Output the next frame bit on each device falling edge; data_oe holds between falls.
                if (fall) begin
                    data_oe_n = ~frame[0];
                    frame_n   = {1'b0, frame[9:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd9)
                        state_n = S_ACK;
                end
            end
            S_ACK: begin
                data_oe_n = 1'b0;
                if (fall) begin
                    if (sync_data) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (sync_clk && sync_data) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Watchdog abort only applies when the state logic is not already returning to idle.
        if (state inside {S_SHIFT, S_ACK, S_WAIT_IDLE}) begin
            wd_cnt_n = wd_cnt + 1'b1;
            if (wd_cnt == WW'(TIMEOUT_CYCLES - 1) && state_n != S_IDLE) begin
                state_n   = S_IDLE;
                err_n     = 1'b1;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
            end
        end

        busy_n = (state_n != S_IDLE);
    end

    assign bus.tx_busy     = busy;
    assign bus.tx_done     = done;
    assign bus.tx_err      = err;
    assign bus.ps2_clk_oe  = clk_oe;
    assign bus.ps2_data_oe = data_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model plus a device BFM that clocks
// with a 40-cycle period and samples data on its rising edge.
module tb_ps2_host_tx;
    logic clk;
    logic reset;
    logic dev_clk_low;
    logic dev_data_low;
    int   dev_bit;
    int   n_checks;
    int   n_fail;
    int   done_total;
    int   err_total;
    int   bad_pulse;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_done) done_total++;
        if (bus.tx_err) err_total++;
        if ((bus.tx_done && bus.tx_err) || ((bus.tx_done || bus.tx_err) && bus.tx_busy))
            bad_pulse++;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no end expected end");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Device side of one frame: start bit read after clock release, ten device clocks, optional ACK.
    task automatic dev_run(input bit ack, output logic [10:0] bits);
        bit seen;
        bits = '0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.ps2_clk_oe && !bus.ps2_data_in) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("rts_seen", 32'(seen), 32'd1);
            return;
        end
        repeat (10) @(negedge clk);
        bits[0] = bus.ps2_data_in;
        for (int k = 1; k <= 10; k++) begin
            dev_bit     = k;
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k]     = bus.ps2_data_in;
            repeat (20) @(negedge clk);
        end
        dev_bit = 11;
        if (ack) dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_bit = 0;
    endtask

    // Waits for the done/err pulse; optionally issues the next start in that same idle cycle.
    task automatic wait_result(input string tag, input bit exp_done, input bit b2b, input logic [7:0] nd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.tx_done || bus.tx_err) begin
                seen = 1'b1;
                check({tag, "_done"}, 32'(bus.tx_done), 32'(exp_done));
                check({tag, "_err"}, 32'(bus.tx_err), 32'(!exp_done));
                check({tag, "_busy"}, 32'(bus.tx_busy), 32'd0);
                check({tag, "_oe"}, {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
                if (b2b) begin
                    bus.tx_data  = nd;
                    bus.tx_start = 1'b1;
                    @(negedge clk);
                    bus.tx_start = 1'b0;
                    check({tag, "_b2b_busy"}, 32'(bus.tx_busy), 32'd1);
                end
                break;
            end
        end
        if (!seen) check({tag, "_pulse_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [10:0] bits;
        int          cnt;
        int          d0;
        int          e0;

        n_checks     = 0;
        n_fail       = 0;
        done_total   = 0;
        err_total    = 0;
        bad_pulse    = 0;
        dev_bit      = 0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_start = 1'b0;
        reset        = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_done", 32'(bus.tx_done), 32'd0);
        check("rst_err", 32'(bus.tx_err), 32'd0);
        check("rst_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xF4 with inhibit/RTS timing
        start_tx(8'hF4);
        check("t1_busy", 32'(bus.tx_busy), 32'd1);
        cnt = 0;
        while (bus.ps2_clk_oe && !bus.ps2_data_oe && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t1_inhibit_len", 32'(cnt), 32'd8);
        cnt = 0;
        while (bus.ps2_clk_oe && bus.ps2_data_oe && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("t1_rts_len", 32'(cnt), 32'd1);
        fork
            dev_run(1'b1, bits);
            wait_result("t1", 1'b1, 1'b0, 8'h00);
        join
        check("t1_frame", 32'(bits), 32'h5E8);

        // 2: 0xFF then back-to-back 0xED
        start_tx(8'hFF);
        fork
            dev_run(1'b1, bits);
            wait_result("t2a", 1'b1, 1'b1, 8'hED);
        join
        check("t2_frame_ff", 32'(bits), 32'h7FE);
        fork
            dev_run(1'b1, bits);
            wait_result("t2b", 1'b1, 1'b0, 8'h00);
        join
        check("t2_frame_ed", 32'(bits), 32'h7DA);

        // 3: no ACK
        start_tx(8'hF4);
        fork
            dev_run(1'b0, bits);
            wait_result("t3", 1'b0, 1'b0, 8'h00);
        join
        check("t3_frame", 32'(bits), 32'h5E8);

        // 4: device never clocks
        start_tx(8'hF4);
        for (int i = 0; i < 100; i++) begin
            if (!bus.ps2_clk_oe) break;
            @(negedge clk);
        end
        check("t4_rts_exit", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd1);
        cnt = 0;
        while (!bus.tx_err && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_timeout_len", 32'(cnt), 32'd2000);
        check("t4_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        check("t4_busy", 32'(bus.tx_busy), 32'd0);
        repeat (5) @(negedge clk);

        // 5: start pulse with 0x00 mid-frame is ignored
        start_tx(8'hED);
        fork
            dev_run(1'b1, bits);
            wait_result("t5", 1'b1, 1'b0, 8'h00);
            begin
                repeat (150) @(negedge clk);
                bus.tx_data  = 8'h00;
                bus.tx_start = 1'b1;
                @(negedge clk);
                bus.tx_start = 1'b0;
            end
        join
        check("t5_frame", 32'(bits), 32'h7DA);
        repeat (5) @(negedge clk);

        // 6: asynchronous reset at bit 5, then a clean send
        d0 = done_total;
        e0 = err_total;
        start_tx(8'hF4);
        fork
            dev_run(1'b1, bits);
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk);
                    if (dev_bit >= 5) break;
                end
                #2;
                reset = 1'b0;
                #1;
                check("t6_rst_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
                check("t6_rst_busy", 32'(bus.tx_busy), 32'd0);
                repeat (5) @(negedge clk);
                reset = 1'b1;
            end
        join
        #1;
        check("t6_no_pulse", 32'((done_total - d0) + (err_total - e0)), 32'd0);
        repeat (10) @(negedge clk);
        start_tx(8'hF4);
        fork
            dev_run(1'b1, bits);
            wait_result("t6", 1'b1, 1'b0, 8'h00);
        join
        check("t6_frame", 32'(bits), 32'h5E8);

        repeat (5) @(negedge clk);
        check("done_total", 32'(done_total), 32'd5);
        check("err_total", 32'(err_total), 32'd2);
        check("pulse_overlap", 32'(bad_pulse), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
